tx_pkt_encoder: RTL
===================

Name: tx_pkt_encoder

Overview:
Transmit-side packet encoder for the clustering/routing node; the counterpart of the Q-table receiver.
- Latches the node's own routing state on a start pulse.
- Serialises it big-endian, one byte per cycle, into the 8-bit-wide transmit packet memory.
- Hands the packet to the radio with a req/ack handshake.
- Produces the fSourceID/fSourceHops/fQValue/fEnergyLeft/fHopsFromCH/fChosenCH fields that neighbouring receivers parse.

Parameters:
- MEM_WIDTH, 8, byte width of the packet memory.
- MEM_DEPTH, 2048, packet memory depth in bytes.
- ADDR_WIDTH, 11, log2(MEM_DEPTH).
- WORD_WIDTH, 16, width of every packet field except type.
- BROADCAST_ID, 16'hFFFF, destination written for heartbeat packets.

Ports:
- clk  in  1  system clock, rising edge.
- nrst  in  1  asynchronous active-low reset.
- en  in  1  start pulse; sampled only in IDLE.
- pktType  in  2  1=heartbeat (HB), 2=neighbour-update (NU); 0 and 3 invalid.
- baseAddr  in  ADDR_WIDTH  first memory byte address of the packet.
- myNodeID  in  WORD_WIDTH  own node ID.
- myHops  in  WORD_WIDTH  own hop count.
- myQValue  in  WORD_WIDTH  own Q-value (Q-format, passed unchanged).
- myEnergy  in  WORD_WIDTH  remaining energy (passed unchanged).
- hopsFromCH  in  WORD_WIDTH  hops to chosen cluster head.
- chosenCH  in  WORD_WIDTH  chosen cluster head ID.
- chosenHop  in  WORD_WIDTH  next-hop destination for NU packets.
- txAck  in  1  radio accepted the packet.
- memWrEn  out  1  packet memory write strobe.
- memAddr  out  ADDR_WIDTH  packet memory write address.
- memData  out  MEM_WIDTH  packet memory write data.
- txReq  out  1  packet ready for the radio.
- pktLen  out  8  byte length of the current or last packet.
- busy  out  1  high in any state other than IDLE.
- TXENC_done  out  1  one-cycle completion pulse.
- TXENC_err  out  1  one-cycle pulse when a start carries an invalid pktType.

Behaviour:
- Reset (async, nrst=0): state=IDLE; memWrEn, txReq, busy, TXENC_done, TXENC_err = 0; memAddr=0; memData=0; pktLen=0; byte counter=0; field latches cleared.
- States: IDLE -> WRITE -> REQ -> DONE -> IDLE.
- IDLE, en=1, pktType valid:
  - Latch all field inputs and baseAddr.
  - pktLen = 7 for HB, 15 for NU.
  - Go to WRITE.
- IDLE, en=1, pktType invalid: pulse TXENC_err next cycle, stay IDLE, no memory writes.
- Byte map, big-endian (high byte first), offsets:
  - 0: {6'b0, pktType}
  - 1-2: destination (BROADCAST_ID for HB, chosenHop for NU)
  - 3-4: myNodeID
  - 5-6: myHops
  - NU only: 7-8 myQValue, 9-10 myEnergy, 11-12 hopsFromCH, 13-14 chosenCH.
- WRITE:
  - One byte per cycle with memWrEn=1 and memAddr = (baseAddr + offset) mod MEM_DEPTH; address wraps 2047 -> 0.
  - If en is sampled at cycle N, byte 0 is written in cycle N+1 and the last byte in cycle N+pktLen.
  - After the last byte go to REQ; memWrEn deasserts that cycle.
- REQ:
  - txReq=1 from cycle N+pktLen+1 and held until txAck=1 is sampled.
  - txAck seen outside REQ is ignored.
  - Go to DONE. If txAck is already high on REQ entry, REQ lasts exactly one cycle.
- DONE: TXENC_done=1 for one cycle, txReq=0, then IDLE. Accept-to-done minimum latency = pktLen+2 cycles.
- Field inputs may change after the start cycle; only the latched values are written.
- en while busy is ignored; it is not queued.
- Reset mid-packet aborts immediately. Partially written bytes stay in memory; no done pulse.
- pktLen holds its value after DONE until the next valid start.
- busy=1 in WRITE, REQ and DONE.

Test Plan:
- Reset then HB with myNodeID=16'd25, myHops=16'd2, baseAddr=0 -> bytes 01 FF FF 00 19 00 02 at addresses 0-6; pktLen=7; txReq at cycle 8 after start; ack one cycle later -> TXENC_done one cycle after ack.
- NU with myNodeID=65, myHops=2, myQValue=16'h0c00, myEnergy=16'h3333, hopsFromCH=2, chosenCH=25, chosenHop=13, baseAddr=16 -> bytes 02 00 0D 00 41 00 02 0C 00 33 33 00 02 00 19 at addresses 16-30; pktLen=15.
- NU at baseAddr=2040 -> bytes 0-7 at addresses 2040-2047, bytes 8-14 at addresses 0-6; no write outside the 15 bytes.
- txAck held low 5 cycles in REQ, then en pulses and input changes during WRITE/REQ -> txReq stays high until ack; no second packet; memory contents match the first latched values.
- pktType=0 start -> TXENC_err pulse, no memWrEn, busy stays 0. Then nrst=0 at byte 4 of an NU -> all outputs 0 immediately; a fresh HB after reset completes normally.

Source files
------------

// File: rtl/tx_pkt_encoder.sv
// Transmit packet encoder: latches the node's routing state on a start pulse,
// serialises it big-endian one byte per cycle into packet memory, then hands
// the packet to the radio with a req/ack handshake.
module tx_pkt_encoder #(
  parameter int unsigned          MEM_WIDTH    = 8,
  parameter int unsigned          MEM_DEPTH    = 2048,
  parameter int unsigned          ADDR_WIDTH   = 11,
  parameter int unsigned          WORD_WIDTH   = 16,
  parameter logic [WORD_WIDTH-1:0] BROADCAST_ID = 16'hFFFF
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [1:0]            pktType,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic [WORD_WIDTH-1:0] myNodeID,
  input  logic [WORD_WIDTH-1:0] myHops,
  input  logic [WORD_WIDTH-1:0] myQValue,
  input  logic [WORD_WIDTH-1:0] myEnergy,
  input  logic [WORD_WIDTH-1:0] hopsFromCH,
  input  logic [WORD_WIDTH-1:0] chosenCH,
  input  logic [WORD_WIDTH-1:0] chosenHop,
  input  logic                  txAck,
  output logic                  memWrEn,
  output logic [ADDR_WIDTH-1:0] memAddr,
  output logic [MEM_WIDTH-1:0]  memData,
  output logic                  txReq,
  output logic [7:0]            pktLen,
  output logic                  busy,
  output logic                  TXENC_done,
  output logic                  TXENC_err
);

  typedef enum logic [1:0] {StIdle, StWrite, StReq, StDone} state_e;

  localparam logic [1:0] TypeHb = 2'd1;
  localparam logic [1:0] TypeNu = 2'd2;

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [7:0]            len_q, len_d;
  logic                  err_q, err_d;
  logic                  start_ok;

  logic [1:0]            type_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [WORD_WIDTH-1:0] dst_q, id_q, hops_q, qval_q, energy_q, hfc_q, ch_q;

  logic [3:0]            idx;
  logic [WORD_WIDTH-1:0] word_sel;
  logic [MEM_WIDTH-1:0]  byte_sel;
  logic [ADDR_WIDTH-1:0] addr_sum;
  logic                  last_byte;

  // Next-state logic and start validation.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    err_d    = 1'b0;
    start_ok = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (en) begin
          if (pktType == TypeHb || pktType == TypeNu) begin
            start_ok = 1'b1;
            state_d  = StWrite;
            cnt_d    = '0;
            len_d    = (pktType == TypeHb) ? 8'd7 : 8'd15;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWrite: begin
        if (last_byte) begin
          state_d = StReq;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      StReq: begin
        if (txAck) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  // Field latches; later input changes must not reach the packet.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      type_q   <= '0;
      base_q   <= '0;
      dst_q    <= '0;
      id_q     <= '0;
      hops_q   <= '0;
      qval_q   <= '0;
      energy_q <= '0;
      hfc_q    <= '0;
      ch_q     <= '0;
    end else if (start_ok) begin
      type_q   <= pktType;
      base_q   <= baseAddr;
      dst_q    <= (pktType == TypeHb) ? BROADCAST_ID : chosenHop;
      id_q     <= myNodeID;
      hops_q   <= myHops;
      qval_q   <= myQValue;
      energy_q <= myEnergy;
      hfc_q    <= hopsFromCH;
      ch_q     <= chosenCH;
    end
  end

  // Byte mux: offset 0 is the type, then each 16-bit field high byte first.
  always_comb begin
    idx      = cnt_q - 4'd1;
    word_sel = '0;
    byte_sel = '0;
    unique case (idx[3:1])
      3'd0:    word_sel = dst_q;
      3'd1:    word_sel = id_q;
      3'd2:    word_sel = hops_q;
      3'd3:    word_sel = qval_q;
      3'd4:    word_sel = energy_q;
      3'd5:    word_sel = hfc_q;
      3'd6:    word_sel = ch_q;
      default: word_sel = '0;
    endcase
    if (cnt_q == 4'd0) begin
      byte_sel = MEM_WIDTH'(type_q);
    end else if (idx[0]) begin
      byte_sel = word_sel[MEM_WIDTH-1:0];
    end else begin
      byte_sel = word_sel[WORD_WIDTH-1 -: MEM_WIDTH];
    end
  end

  // Outputs decoded from state; address wraps at the memory depth.
  always_comb begin
    last_byte  = ({4'd0, cnt_q} == (len_q - 8'd1));
    addr_sum   = (base_q + ADDR_WIDTH'(cnt_q)) & ADDR_WIDTH'(MEM_DEPTH - 1);
    memWrEn    = (state_q == StWrite);
    memAddr    = memWrEn ? addr_sum : '0;
    memData    = memWrEn ? byte_sel : '0;
    txReq      = (state_q == StReq);
    busy       = (state_q != StIdle);
    TXENC_done = (state_q == StDone);
    TXENC_err  = err_q;
    pktLen     = len_q;
  end

endmodule
